// File: rtl/bus_pkg.sv
// Shared widths and phase encoding for the uio external bus sequencer.
package bus_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 4;
  localparam int UIO_W  = 8;

  typedef enum logic [1:0] {
    PH_IDLE    = 2'd0,
    PH_ADDR_HI = 2'd1,
    PH_ACCESS  = 2'd2,
    PH_TURN    = 2'd3
  } phase_e;
endpackage

// File: rtl/bus_rr_arbiter.sv
// Two-port arbiter: round-robin or fixed priority (port 0), grants only while enabled.
module bus_rr_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       last
);
  // last = 1 means port 1 was granted most recently
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = (RR_EN && !last) ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       last <= 1'b1;
    else if (|gnt) last <= gnt[1];
  end
endmodule

// File: rtl/uio_bus_sequencer.sv
// Multiplexes 12-bit address / 4-bit data transactions from two requesters
// onto the shared uio pin bank: ADDR_HI, ACCESS (WAIT_CYCLES+1), TURN.
module uio_bus_sequencer
  import bus_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int RR_EN       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              done0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  input  logic [UIO_W-1:0]  uio_in,
  output logic [UIO_W-1:0]  uio_out,
  output logic [UIO_W-1:0]  uio_oe,
  output logic [1:0]        mem_ph,
  output logic              mem_we
);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  phase_e            state;
  logic              sel;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        cnt;
  logic [1:0]        gnt;
  logic              last_unused;
  logic              uio_in_unused;

  assign uio_in_unused = ^uio_in[7:4];

  bus_rr_arbiter #(.RR_EN(RR_EN != 0)) u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  ({req1, req0}),
    .en   (state == PH_IDLE),
    .gnt  (gnt),
    .last (last_unused)
  );

  assign mem_ph = state;
  assign busy   = (state != PH_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= PH_IDLE;
      uio_out <= '0;
      uio_oe  <= '0;
      mem_we  <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      rdata   <= '0;
      sel     <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        PH_IDLE: begin
          uio_out <= '0;
          uio_oe  <= '0;
          mem_we  <= 1'b0;
          if (|gnt) begin
            sel     <= gnt[1];
            we_q    <= gnt[1] ? we1 : we0;
            addr_q  <= gnt[1] ? addr1 : addr0;
            wdata_q <= gnt[1] ? wdata1 : wdata0;
            uio_out <= gnt[1] ? addr1[11:4] : addr0[11:4];
            uio_oe  <= '1;
            state   <= PH_ADDR_HI;
          end
        end
        PH_ADDR_HI: begin
          // read keeps the low nibble undriven so uio_in can be sampled
          uio_out <= {addr_q[3:0], (we_q ? wdata_q : 4'h0)};
          uio_oe  <= {4'hF, {4{we_q}}};
          mem_we  <= we_q;
          cnt     <= WAIT_INIT;
          state   <= PH_ACCESS;
        end
        PH_ACCESS: begin
          if (cnt == 4'd0) begin
            if (!we_q) rdata <= uio_in[3:0];
            uio_out <= '0;
            uio_oe  <= '0;
            mem_we  <= 1'b0;
            done0   <= !sel;
            done1   <= sel;
            state   <= PH_TURN;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        PH_TURN: begin
          state <= PH_IDLE;
        end
        default: state <= PH_IDLE;
      endcase
    end
  end
endmodule
